// File: rtl/arith_pkg.sv
// Shared definitions for the pipelined arithmetic unit: opcodes, status bit
// positions and the issue state machine encoding.
package arith_pkg;

    localparam logic [6:0] OP_NOP = 7'd0;
    localparam logic [6:0] OP_ADD = 7'd1;
    localparam logic [6:0] OP_SUB = 7'd2;
    localparam logic [6:0] OP_MUL = 7'd3;

    localparam int unsigned ST_OVF = 1;
    localparam int unsigned ST_UNF = 0;

    typedef enum logic {
        ST_IDLE,
        ST_MUL_BUSY
    } state_e;

endpackage

// File: rtl/arith_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_BITS multiplier bits per cycle.
// The start cycle performs the first step, and done_o/product_o reflect the
// step being taken in the current cycle, so the caller can register the result
// on the same edge that completes it.
module arith_mul_iter #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned MUL_BITS = 1
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     mcand_i,
    input  logic [WIDTH-1:0]     mplier_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int unsigned Steps = WIDTH / MUL_BITS;
    localparam int unsigned CntW  = $clog2(Steps + 1);
    localparam logic [CntW-1:0] StepsCnt = CntW'(Steps);
    localparam logic [CntW-1:0] OneCnt   = CntW'(1);

    logic                 busy_q, busy_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CntW-1:0]      cnt_q, cnt_d;

    logic                 active;
    logic [2*WIDTH-1:0]   src_acc, src_mcand, step_acc;
    logic [WIDTH-1:0]     src_mplier;
    logic [CntW-1:0]      src_cnt;

    always_comb begin
        active     = start_i | busy_q;
        // A start bypasses the registers so the first step happens at issue.
        src_acc    = start_i ? '0 : acc_q;
        src_mcand  = start_i ? {{WIDTH{1'b0}}, mcand_i} : mcand_q;
        src_mplier = start_i ? mplier_i : mplier_q;
        src_cnt    = start_i ? StepsCnt : cnt_q;

        step_acc = src_acc;
        for (int i = 0; i < int'(MUL_BITS); i++) begin
            if (src_mplier[i]) begin
                step_acc = step_acc + (src_mcand << i);
            end
        end

        busy_d   = busy_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (active) begin
            acc_d    = step_acc;
            mcand_d  = src_mcand << MUL_BITS;
            mplier_d = src_mplier >> MUL_BITS;
            cnt_d    = src_cnt - OneCnt;
            busy_d   = (src_cnt != OneCnt);
        end

        done_o    = active && (src_cnt == OneCnt);
        product_o = step_acc;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            busy_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/arith_unit_pipe.sv
// Arithmetic unit between operand fetch and register write-back: single-cycle
// add/sub, iterative multiply with issue back-pressure, registered results.
module arith_unit_pipe
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned MUL_BITS = 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              enable_i,
    output logic              ready_o,
    input  logic              isWb_i,
    input  logic [ADDR_W-1:0] wbAddress_i,
    input  logic [6:0]        opCode_i,
    input  logic [WIDTH-1:0]  pOperand_i,
    input  logic [WIDTH-1:0]  sOperand_i,
    output logic              valid_o,
    output logic              wbEnable_o,
    output logic [ADDR_W-1:0] wbAddress_o,
    output logic [WIDTH-1:0]  wbData_o,
    output logic [1:0]        statusWriteback_o
);

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic                wb_en_q, wb_en_d;
    logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
    logic [WIDTH-1:0]    wb_data_q, wb_data_d;
    logic [1:0]          status_q, status_d;
    logic                mul_wb_q, mul_wb_d;
    logic [ADDR_W-1:0]   mul_addr_q, mul_addr_d;

    logic                issue;
    logic                mul_start;
    logic                mul_done;
    logic [2*WIDTH-1:0]  mul_product;
    logic [WIDTH:0]      sum;
    logic [WIDTH-1:0]    diff;

    assign ready_o   = (state_q == ST_IDLE);
    assign issue     = enable_i & ready_o;
    assign mul_start = issue && (opCode_i == OP_MUL);
    assign sum       = {1'b0, pOperand_i} + {1'b0, sOperand_i};
    assign diff      = pOperand_i - sOperand_i;

    arith_mul_iter #(
        .WIDTH    (WIDTH),
        .MUL_BITS (MUL_BITS)
    ) u_mul (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .start_i   (mul_start),
        .mcand_i   (pOperand_i),
        .mplier_i  (sOperand_i),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        state_d    = state_q;
        valid_d    = 1'b0;
        wb_en_d    = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        status_d   = status_q;
        mul_wb_d   = mul_wb_q;
        mul_addr_d = mul_addr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    case (opCode_i)
                        OP_ADD: begin
                            valid_d          = 1'b1;
                            wb_en_d          = isWb_i;
                            wb_addr_d        = wbAddress_i;
                            wb_data_d        = sum[WIDTH-1:0];
                            status_d         = '0;
                            status_d[ST_OVF] = sum[WIDTH];
                        end
                        OP_SUB: begin
                            valid_d          = 1'b1;
                            wb_en_d          = isWb_i;
                            wb_addr_d        = wbAddress_i;
                            wb_data_d        = diff;
                            status_d         = '0;
                            status_d[ST_UNF] = (sOperand_i > pOperand_i);
                        end
                        OP_MUL: begin
                            mul_wb_d   = isWb_i;
                            mul_addr_d = wbAddress_i;
                            // Only a single-step multiply finishes at issue.
                            if (mul_done) begin
                                valid_d          = 1'b1;
                                wb_en_d          = isWb_i;
                                wb_addr_d        = wbAddress_i;
                                wb_data_d        = mul_product[WIDTH-1:0];
                                status_d         = '0;
                                status_d[ST_OVF] = |mul_product[2*WIDTH-1:WIDTH];
                            end else begin
                                state_d = ST_MUL_BUSY;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL_BUSY: begin
                if (mul_done) begin
                    state_d          = ST_IDLE;
                    valid_d          = 1'b1;
                    wb_en_d          = mul_wb_q;
                    wb_addr_d        = mul_addr_q;
                    wb_data_d        = mul_product[WIDTH-1:0];
                    status_d         = '0;
                    status_d[ST_OVF] = |mul_product[2*WIDTH-1:WIDTH];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            status_q   <= '0;
            mul_wb_q   <= 1'b0;
            mul_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            wb_en_q    <= wb_en_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            status_q   <= status_d;
            mul_wb_q   <= mul_wb_d;
            mul_addr_q <= mul_addr_d;
        end
    end

    assign valid_o           = valid_q;
    assign wbEnable_o        = wb_en_q;
    assign wbAddress_o       = wb_addr_q;
    assign wbData_o          = wb_data_q;
    assign statusWriteback_o = status_q;

endmodule
